// File: rtl/types_pkg.sv
// Shared types for the mispredict recovery path: register-file sizing,
// the checkpoint snapshot layout and the recovery sequencer states.
package types_pkg;

    localparam int unsigned NUM_PR = 128;
    localparam int unsigned PR_W   = $clog2(NUM_PR);

    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [4:0]        rob_tag;
        logic [NUM_PR-1:0] reset_reg_rdy_table;
    } checkpoint;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        WALK,
        DONE
    } recovery_state_t;

endpackage

// File: rtl/pr_prio_enc.sv
// Lowest-set-bit encoder over the physical-register bitmap.
module pr_prio_enc #(
    parameter int unsigned NUM_PR = 128,
    parameter int unsigned PR_W   = $clog2(NUM_PR)
) (
    input  logic [NUM_PR-1:0] vec,
    output logic [PR_W-1:0]   idx,
    output logic              any
);

    // Scan upward; the first set bit found wins, giving the lowest index.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < NUM_PR; i++) begin
            if (vec[i] && !any) begin
                idx = PR_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_recovery.sv
// Mispredict recovery sequencer: latches a checkpoint, pulses flush/redirect,
// then returns each marked physical register to the free list in index order.
module branch_recovery
    import types_pkg::*;
#(
    parameter int unsigned NUM_PR = types_pkg::NUM_PR,
    parameter int unsigned PR_W   = types_pkg::PR_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            checkpoint_valid,
    input  checkpoint       snapshot,
    input  logic [31:0]     mispredict_target,
    output logic            flush,
    output logic [4:0]      flush_rob_tag,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc,
    output logic [PR_W-1:0] free_pr,
    output logic            free_pr_valid,
    input  logic            free_pr_ready,
    output logic            stall,
    output logic            busy,
    output logic            recovery_done
);

    recovery_state_t   state_q, state_d;
    logic [NUM_PR-1:0] bitmap_q, bitmap_d;
    logic [31:0]       target_q, target_d;
    logic [4:0]        tag_q, tag_d;

    logic [PR_W-1:0]   enc_idx;
    logic              enc_any;

    pr_prio_enc #(
        .NUM_PR (NUM_PR),
        .PR_W   (PR_W)
    ) u_enc (
        .vec (bitmap_q),
        .idx (enc_idx),
        .any (enc_any)
    );

    // State and latched-snapshot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            bitmap_q <= '0;
            target_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            bitmap_q <= bitmap_d;
            target_q <= target_d;
            tag_q    <= tag_d;
        end
    end

    // Next-state logic: latch in IDLE, clear one bit per accepted free in WALK.
    always_comb begin
        state_d  = state_q;
        bitmap_d = bitmap_q;
        target_d = target_q;
        tag_d    = tag_q;
        unique case (state_q)
            IDLE: begin
                if (checkpoint_valid && snapshot.valid) begin
                    target_d = mispredict_target;
                    tag_d    = snapshot.rob_tag;
                    bitmap_d = snapshot.reset_reg_rdy_table;
                    state_d  = FLUSH;
                end
            end
            FLUSH: state_d = WALK;
            WALK: begin
                if (!enc_any) begin
                    state_d = DONE;
                end else if (free_pr_ready) begin
                    bitmap_d[enc_idx] = 1'b0;
                    if (bitmap_d == '0) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state; only stall sees the live request.
    always_comb begin
        flush          = (state_q == FLUSH);
        redirect_valid = (state_q == FLUSH);
        flush_rob_tag  = tag_q;
        redirect_pc    = target_q;
        free_pr_valid  = (state_q == WALK) && enc_any;
        free_pr        = free_pr_valid ? enc_idx : '0;
        busy           = (state_q != IDLE);
        recovery_done  = (state_q == DONE);
        stall          = (state_q != IDLE) || (checkpoint_valid && snapshot.valid);
    end

endmodule

// File: tb/tb_branch_recovery.sv
// Directed bench for branch_recovery: each step drives inputs just after the
// rising edge and checks outputs on the following falling edge.
module tb_branch_recovery;
    import types_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            checkpoint_valid;
    checkpoint       snapshot;
    logic [31:0]     mispredict_target;
    logic            flush;
    logic [4:0]      flush_rob_tag;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic [PR_W-1:0] free_pr;
    logic            free_pr_valid;
    logic            free_pr_ready;
    logic            stall;
    logic            busy;
    logic            recovery_done;

    int total = 0;
    int bad   = 0;
    int hs    = 0;
    int viol  = 0;
    int hs0;

    int exp1[3] = '{3, 17, 64};
    int exp4[2] = '{9, 40};

    always #5 clk = ~clk;

    branch_recovery #(
        .NUM_PR (128),
        .PR_W   (7)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .checkpoint_valid  (checkpoint_valid),
        .snapshot          (snapshot),
        .mispredict_target (mispredict_target),
        .flush             (flush),
        .flush_rob_tag     (flush_rob_tag),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .free_pr           (free_pr),
        .free_pr_valid     (free_pr_valid),
        .free_pr_ready     (free_pr_ready),
        .stall             (stall),
        .busy              (busy),
        .recovery_done     (recovery_done)
    );

    // Count accepted frees at the edge where the handshake takes effect.
    always @(posedge clk) begin
        if (!reset && free_pr_valid && free_pr_ready) hs++;
    end

    // A new checkpoint while the sequencer is busy is a protocol violation.
    always @(negedge clk) begin
        if (!reset && checkpoint_valid && busy) begin
            viol++;
            $display("note: protocol violation, checkpoint_valid while busy (t=%0t)", $time);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drive_cp(input logic v, input logic [4:0] tag,
                            input logic [31:0] tgt, input logic [127:0] bm);
        checkpoint_valid                 = 1'b1;
        snapshot.valid                   = v;
        snapshot.pc                      = tgt - 32'd4;
        snapshot.rob_tag                 = tag;
        snapshot.reset_reg_rdy_table     = bm;
        mispredict_target                = tgt;
    endtask

    task automatic idle_in();
        checkpoint_valid                 = 1'b0;
        snapshot.valid                   = 1'b1;
        snapshot.rob_tag                 = 5'h1f;
        snapshot.reset_reg_rdy_table     = '1;
        mispredict_target                = 32'hffff_fffc;
    endtask

    logic [127:0] bm;

    initial begin
        reset = 1'b1;
        free_pr_ready = 1'b1;
        snapshot = '0;
        idle_in();
        cyc();
        cyc();
        smp();
        chk("rst_flush", flush, 0);
        chk("rst_rv", redirect_valid, 0);
        chk("rst_fpv", free_pr_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", recovery_done, 0);
        chk("rst_pc", redirect_pc, 0);
        chk("rst_tag", flush_rob_tag, 0);
        cyc();
        reset = 1'b0;

        // Single recovery, bits {3,17,64}
        cyc();
        bm = '0; bm[3] = 1'b1; bm[17] = 1'b1; bm[64] = 1'b1;
        drive_cp(1'b1, 5'd5, 32'h0000_1040, bm);
        smp();
        chk("t1_stall_N", stall, 1);
        chk("t1_busy_N", busy, 0);
        chk("t1_flush_N", flush, 0);
        cyc();
        idle_in();
        smp();
        chk("t1_flush", flush, 1);
        chk("t1_rv", redirect_valid, 1);
        chk("t1_pc", redirect_pc, 32'h0000_1040);
        chk("t1_tag", flush_rob_tag, 5);
        chk("t1_fpv_flush", free_pr_valid, 0);
        foreach (exp1[i]) begin
            cyc();
            smp();
            chk("t1_fpv", free_pr_valid, 1);
            chk("t1_free", free_pr, exp1[i]);
            chk("t1_flush_off", flush, 0);
        end
        cyc();
        smp();
        chk("t1_done", recovery_done, 1);
        chk("t1_fpv_done", free_pr_valid, 0);
        chk("t1_stall_done", stall, 1);
        cyc();
        smp();
        chk("t1_stall_idle", stall, 0);
        chk("t1_busy_idle", busy, 0);
        chk("t1_done_off", recovery_done, 0);

        // Empty bitmap
        cyc();
        drive_cp(1'b1, 5'd9, 32'h0000_0800, '0);
        cyc();
        idle_in();
        smp();
        chk("t2_flush", flush, 1);
        cyc();
        smp();
        chk("t2_fpv", free_pr_valid, 0);
        chk("t2_done_walk", recovery_done, 0);
        chk("t2_busy_walk", busy, 1);
        cyc();
        smp();
        chk("t2_done", recovery_done, 1);
        chk("t2_fpv_done", free_pr_valid, 0);
        cyc();
        smp();
        chk("t2_stall_idle", stall, 0);
        chk("t2_busy_idle", busy, 0);

        // Backpressure, bits {0,127}, ready low 3 cycles per transfer
        cyc();
        bm = '0; bm[0] = 1'b1; bm[127] = 1'b1;
        drive_cp(1'b1, 5'd2, 32'h0000_4000, bm);
        free_pr_ready = 1'b0;
        hs0 = hs;
        cyc();
        idle_in();
        smp();
        chk("t3_flush", flush, 1);
        for (int r = 0; r < 4; r++) begin
            cyc();
            free_pr_ready = (r == 3);
            smp();
            chk("t3_fpv_a", free_pr_valid, 1);
            chk("t3_free_a", free_pr, 0);
        end
        for (int r = 0; r < 4; r++) begin
            cyc();
            free_pr_ready = (r == 3);
            smp();
            chk("t3_fpv_b", free_pr_valid, 1);
            chk("t3_free_b", free_pr, 127);
        end
        cyc();
        smp();
        chk("t3_done", recovery_done, 1);
        chk("t3_fpv_done", free_pr_valid, 0);
        chk("t3_handshakes", hs - hs0, 2);
        cyc();

        // New checkpoint mid-walk must be ignored
        bm = '0; bm[2] = 1'b1; bm[9] = 1'b1; bm[40] = 1'b1;
        drive_cp(1'b1, 5'd7, 32'h0000_2000, bm);
        cyc();
        idle_in();
        smp();
        chk("t4_flush", flush, 1);
        cyc();
        smp();
        chk("t4_free0", free_pr, 2);
        cyc();
        bm = '0; bm[1] = 1'b1;
        drive_cp(1'b1, 5'd12, 32'hdead_0000, bm);
        smp();
        chk("t4_free1", free_pr, exp4[0]);
        chk("t4_stall", stall, 1);
        cyc();
        idle_in();
        smp();
        chk("t4_free2", free_pr, exp4[1]);
        chk("t4_tag_kept", flush_rob_tag, 7);
        chk("t4_pc_kept", redirect_pc, 32'h0000_2000);
        cyc();
        smp();
        chk("t4_done", recovery_done, 1);
        chk("t4_fpv_done", free_pr_valid, 0);
        cyc();
        smp();
        chk("t4_idle_flush", flush, 0);
        chk("t4_idle_busy", busy, 0);
        chk("t4_viol", viol, 1);

        // Reset during the second free of a 5-bit walk
        cyc();
        bm = '0; bm[1] = 1'b1; bm[4] = 1'b1; bm[8] = 1'b1; bm[16] = 1'b1; bm[100] = 1'b1;
        drive_cp(1'b1, 5'd20, 32'h0000_5000, bm);
        cyc();
        idle_in();
        cyc();
        smp();
        chk("t5_free0", free_pr, 1);
        cyc();
        reset = 1'b1;
        smp();
        chk("t5_free1", free_pr, 4);
        cyc();
        reset = 1'b0;
        smp();
        chk("t5_fpv", free_pr_valid, 0);
        chk("t5_free", free_pr, 0);
        chk("t5_flush", flush, 0);
        chk("t5_rv", redirect_valid, 0);
        chk("t5_stall", stall, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", recovery_done, 0);
        chk("t5_pc", redirect_pc, 0);
        chk("t5_tag", flush_rob_tag, 0);
        chk("t5_state", dut.state_q, IDLE);
        cyc();
        bm = '0; bm[5] = 1'b1; bm[6] = 1'b1;
        drive_cp(1'b1, 5'd3, 32'h0000_3000, bm);
        cyc();
        idle_in();
        smp();
        chk("t5r_flush", flush, 1);
        chk("t5r_pc", redirect_pc, 32'h0000_3000);
        chk("t5r_tag", flush_rob_tag, 3);
        cyc();
        smp();
        chk("t5r_free0", free_pr, 5);
        cyc();
        smp();
        chk("t5r_free1", free_pr, 6);
        cyc();
        smp();
        chk("t5r_done", recovery_done, 1);
        cyc();

        // checkpoint_valid with snapshot.valid=0 is ignored
        drive_cp(1'b0, 5'd11, 32'h0000_6000, '1);
        smp();
        chk("t6_stall", stall, 0);
        cyc();
        idle_in();
        smp();
        chk("t6_flush", flush, 0);
        chk("t6_busy", busy, 0);
        chk("t6_fpv", free_pr_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_recovery.md
# branch_recovery

Mispredict recovery sequencer, directly downstream of the checkpoint store. On a valid checkpoint snapshot it latches the snapshot, issues a one-cycle pipeline flush and fetch redirect, then walks the snapshot's `reset_reg_rdy_table` bitmap. Each marked physical register is returned one per cycle to the free-list/ready-table over a valid/ready handshake. Rename and dispatch are stalled until the walk completes.

## Interface
Parameters:
- `NUM_PR`, 128: physical register count; equals the width of `reset_reg_rdy_table`.
- `PR_W`, 7: physical register index width, `$clog2(NUM_PR)`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `checkpoint_valid`  in  1  snapshot from the checkpoint store is valid this cycle.
- `snapshot`  in  `checkpoint`  struct with `valid`, `pc[31:0]`, `rob_tag[4:0]`, `reset_reg_rdy_table[NUM_PR-1:0]`.
- `mispredict_target`  in  32  correct target PC from the branch unit, qualified by `checkpoint_valid`.
- `flush`  out  1  one-cycle pulse: kill all instructions younger than `flush_rob_tag`.
- `flush_rob_tag`  out  5  ROB tag of the mispredicted branch.
- `redirect_valid`  out  1  one-cycle pulse, coincident with `flush`.
- `redirect_pc`  out  32  fetch redirect target.
- `free_pr`  out  `PR_W`  physical register being reclaimed.
- `free_pr_valid`  out  1  `free_pr` is valid.
- `free_pr_ready`  in  1  free-list accepts `free_pr` this cycle.
- `stall`  out  1  hold rename/dispatch.
- `busy`  out  1  recovery in progress; the ROB must not raise a new mispredict while this is high.
- `recovery_done`  out  1  one-cycle pulse when the walk finishes.

## Operation
- FSM states: `IDLE`, `FLUSH`, `WALK`, `DONE`.
- `IDLE`:
  - If `checkpoint_valid && snapshot.valid`, latch `pc_target` = `mispredict_target`, `tag` = `snapshot.rob_tag`, and `bitmap` = `snapshot.reset_reg_rdy_table`.
  - Then go to `FLUSH`.
- `FLUSH`:
  - Drive `flush`=1 and `redirect_valid`=1 for exactly one cycle.
  - `redirect_pc` = latched target; `flush_rob_tag` = latched tag.
  - Next state is always `WALK`.
- `WALK`:
  - If `bitmap`==0: go to `DONE`, with `free_pr_valid`=0.
  - Otherwise drive `free_pr_valid`=1 and `free_pr` = index of the lowest set bit of `bitmap`.
  - On `free_pr_valid && free_pr_ready`, clear that bit.
  - When the handshake clears the last set bit, next state is `DONE`.
  - `free_pr` must hold stable while valid and not ready.
- `DONE`:
  - Drive `recovery_done`=1 for one cycle, then go to `IDLE`.
- `stall` = `(state != IDLE) || (state == IDLE && checkpoint_valid && snapshot.valid)`. This is combinational, so rename stops in the same cycle the mispredict is seen.
- `busy` = `(state != IDLE)`.
- `checkpoint_valid` while not `IDLE` is ignored and does not change the latched contents. Flag it in the bench as a protocol violation.
- `checkpoint_valid` with `snapshot.valid`=0 is ignored.
- Reset:
  - All outputs are 0; the FSM goes to `IDLE`; `bitmap`, target and tag are cleared.
  - Reset asserted mid-walk abandons the walk. No further `free_pr_valid` is driven after the reset edge.
- Free registers are emitted in strictly increasing index order. Each set bit is emitted exactly once.

## Timing
- Cycle N: `checkpoint_valid` sampled in `IDLE`; `stall`=1 combinationally.
- Cycle N+1: `FLUSH`; `flush`=`redirect_valid`=1.
- Cycle N+2: first `WALK` cycle; `free_pr_valid`=1 if the bitmap is non-empty.
- With `free_pr_ready` held at 1 and K bits set: frees occupy N+2 … N+1+K, and `recovery_done` fires at N+2+K.
- With K=0: `WALK` lasts one cycle (N+2) and `recovery_done` fires at N+3.
- `stall` deasserts at N+3+K (back in `IDLE`).
- All outputs are driven from registered state. The only combinational input-to-output path is `checkpoint_valid` → `stall`.

## Structure
- Put `recovery_state_t` (the 4-state enum), `NUM_PR` and `PR_W` in `types_pkg`.
- Reuse the existing `checkpoint` struct from `types_pkg`.
- Sub-module `pr_prio_enc`:
  - Parameterised `NUM_PR`-bit lowest-set-bit encoder.
  - Outputs the index and an `any` flag.
- Everything else stays in `branch_recovery`.

## Test plan
- Single recovery, bitmap bits {3, 17, 64}, target 0x0000_1040, tag 5, ready=1:
  - Flush/redirect one cycle after input, with `redirect_pc`=0x1040 and `flush_rob_tag`=5.
  - Frees emitted as 3, 17, 64 on consecutive cycles.
  - `recovery_done` 4 cycles after flush.
- Empty bitmap:
  - Flush at N+1, no `free_pr_valid`, `recovery_done` at N+3, `stall` low at N+4.
- Backpressure: bits {0, 127}, `free_pr_ready` low 3 cycles per transfer:
  - `free_pr` holds 0 until accepted, then 127.
  - Exactly 2 handshakes.
- New `checkpoint_valid` (different tag/bitmap) arriving mid-`WALK`:
  - Ignored; the original sequence completes unchanged.
- Reset asserted during the second free of a 5-bit walk:
  - Next cycle all outputs are 0 and the FSM is `IDLE`.
  - A subsequent recovery runs cleanly from its start.
- `checkpoint_valid`=1 with `snapshot.valid`=0:
  - No `stall`, no flush, FSM stays `IDLE`.
